// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Draws Pac-Man and the four ghosts into the VGA pixel stream. Sprite
//   positions and Pac-Man's direction are captured into shadow registers on
//   frame_start, so a frame is never drawn from a half-updated set of
//   positions. Each pixel takes a fixed 2-cycle path: a hit test on the
//   shadow positions, then priority/colour selection.
//
//   Build option: define PACMAN_MOUTH_EN to cut a mouth wedge from Pac-Man
//   facing his last move direction. The mouth opens and closes every 8
//   frames. Without the macro Pac-Man is a full square.
//
//   Death sequence FSM
//   state | meaning
//   ALIVE | normal drawing, all sprites visible
//   DYING | ghosts hidden, Pac-Man blinks; runs DEATH_FRAMES frames
module sprite_compositor #(
    parameter int          SPRITE_SIZE  = 16,
    parameter int          DEATH_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8,
    parameter logic [11:0] BG_RGB       = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [10:0] pacman_pos_x,
    input  logic [9:0]  pacman_pos_y,
    input  logic [10:0] blinky_pos_x,
    input  logic [9:0]  blinky_pos_y,
    input  logic [10:0] pinky_pos_x,
    input  logic [9:0]  pinky_pos_y,
    input  logic [10:0] inky_pos_x,
    input  logic [9:0]  inky_pos_y,
    input  logic [10:0] clyde_pos_x,
    input  logic [9:0]  clyde_pos_y,
    input  logic        pacman_is_dead,
    input  logic [3:0]  pacman_dir,
    output logic [11:0] rgb,
    output logic        rgb_valid,
    output logic [4:0]  sprite_hit
);

    localparam int CW = $clog2(DEATH_FRAMES + 1);

    localparam logic [11:0] PACMAN_RGB = 12'hFF0;
    localparam logic [11:0] BLINKY_RGB = 12'hF00;
    localparam logic [11:0] PINKY_RGB  = 12'hF8F;
    localparam logic [11:0] INKY_RGB   = 12'h0FF;
    localparam logic [11:0] CLYDE_RGB  = 12'hF80;

    typedef enum logic {ALIVE, DYING} state_t;

    state_t          state;
    logic [CW-1:0]   death_cnt;
    logic            dead_q;

    logic [10:0]     pos_x [5];
    logic [9:0]      pos_y [5];
    logic [10:0]     sh_x  [5];
    logic [9:0]      sh_y  [5];
    logic            shadow_ok;

    logic [4:0]      hit_raw;
    logic            wedge;
    logic            pac_blink_on;

    logic [4:0]      s1_hit;
    logic            s1_valid;
    logic            s1_pac_show;
    logic            s1_ghost_show;
    logic [4:0]      s1_vis;

    // Gather the live position inputs in sprite-index order (0 = Pac-Man).
    always_comb begin
        pos_x[0] = pacman_pos_x;  pos_y[0] = pacman_pos_y;
        pos_x[1] = blinky_pos_x;  pos_y[1] = blinky_pos_y;
        pos_x[2] = pinky_pos_x;   pos_y[2] = pinky_pos_y;
        pos_x[3] = inky_pos_x;    pos_y[3] = inky_pos_y;
        pos_x[4] = clyde_pos_x;   pos_y[4] = clyde_pos_y;
    end

    // Capture positions once per frame; the copy takes effect next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
            end
            shadow_ok <= 1'b0;
        end else if (frame_start) begin
            for (int i = 0; i < 5; i++) begin
                sh_x[i] <= pos_x[i];
                sh_y[i] <= pos_y[i];
            end
            shadow_ok <= 1'b1;
        end
    end

    // Death sequence: rising edge of pacman_is_dead (re)starts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ALIVE;
            death_cnt <= '0;
            dead_q    <= 1'b0;
        end else begin
            dead_q <= pacman_is_dead;
            if (pacman_is_dead && !dead_q) begin
                state     <= DYING;
                death_cnt <= '0;
            end else if (frame_start && state == DYING) begin
                if (death_cnt == CW'(DEATH_FRAMES - 1)) begin
                    state     <= ALIVE;
                    death_cnt <= '0;
                end else begin
                    death_cnt <= death_cnt + CW'(1);
                end
            end
        end
    end

    assign pac_blink_on = ((int'(death_cnt) / BLINK_PERIOD) % 2) == 0;

    // Rectangle test; bounds are one bit wider so sprites past the edge clip.
    always_comb begin
        hit_raw = '0;
        for (int i = 0; i < 5; i++) begin
            hit_raw[i] = shadow_ok
                && (pixel_x >= sh_x[i])
                && ({1'b0, pixel_x} < ({1'b0, sh_x[i]} + 12'(SPRITE_SIZE)))
                && (pixel_y >= sh_y[i])
                && ({1'b0, pixel_y} < ({1'b0, sh_y[i]} + 11'(SPRITE_SIZE)));
        end
    end

`ifdef PACMAN_MOUTH_EN
    localparam int OW = $clog2(SPRITE_SIZE);
    localparam int AW = OW + 2;

    logic [3:0]           last_dir;
    logic [3:0]           frame_no;
    logic [OW-1:0]        off_x;
    logic [OW-1:0]        off_y;
    logic signed [AW-1:0] cx;
    logic signed [AW-1:0] cy;
    logic signed [AW-1:0] ax;
    logic signed [AW-1:0] pp;
    logic signed [AW-1:0] pp_mag;

    // Remember the last real move direction and a free-running frame count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dir <= 4'b0001;
            frame_no <= '0;
        end else if (frame_start) begin
            frame_no <= frame_no + 4'd1;
            if (pacman_dir != 4'b0000)
                last_dir <= pacman_dir;
        end
    end

    // Offsets are doubled about the sprite centre so the centre sits between
    // pixels; the wedge is the forward cone |perpendicular| < axial.
    always_comb begin
        off_x  = OW'(pixel_x) - OW'(sh_x[0]);
        off_y  = OW'(pixel_y) - OW'(sh_y[0]);
        cx     = $signed({1'b0, off_x, 1'b0}) - AW'(SPRITE_SIZE - 1);
        cy     = $signed({1'b0, off_y, 1'b0}) - AW'(SPRITE_SIZE - 1);
        ax     = cx;
        pp     = cy;
        case (last_dir)
            4'b0010: begin ax = -cy; pp = cx; end
            4'b0100: begin ax = cy;  pp = cx; end
            4'b1000: begin ax = -cx; pp = cy; end
            default: begin ax = cx;  pp = cy; end
        endcase
        pp_mag = pp[AW-1] ? -pp : pp;
        wedge  = !frame_no[3] && (ax > 0) && (pp_mag < ax);
    end
`else
    logic unused_dir;
    assign unused_dir = ^pacman_dir;
    assign wedge      = 1'b0;
`endif

    // Stage 1: hit vector, valid and the death-sequence visibility masks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hit        <= '0;
            s1_valid      <= 1'b0;
            s1_pac_show   <= 1'b1;
            s1_ghost_show <= 1'b1;
        end else begin
            s1_valid      <= pixel_valid;
            s1_hit        <= pixel_valid ? {hit_raw[4:1], hit_raw[0] & ~wedge} : 5'b0;
            s1_pac_show   <= (state == ALIVE) || pac_blink_on;
            s1_ghost_show <= (state == ALIVE);
        end
    end

    assign s1_vis = s1_hit & {{4{s1_ghost_show}}, s1_pac_show};

    // Stage 2: priority colour select.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb        <= BG_RGB;
            rgb_valid  <= 1'b0;
            sprite_hit <= '0;
        end else begin
            rgb_valid  <= s1_valid;
            sprite_hit <= s1_hit;
            if (!s1_valid)      rgb <= BG_RGB;
            else if (s1_vis[0]) rgb <= PACMAN_RGB;
            else if (s1_vis[1]) rgb <= BLINKY_RGB;
            else if (s1_vis[2]) rgb <= PINKY_RGB;
            else if (s1_vis[3]) rgb <= INKY_RGB;
            else if (s1_vis[4]) rgb <= CLYDE_RGB;
            else                rgb <= BG_RGB;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a reference model predicts each
// visible pixel's colour and hit vector at issue time; a monitor compares the
// DUT output against the queue. Honours PACMAN_MOUTH_EN like the design.
module tb_sprite_compositor;

    localparam logic [11:0] BG = 12'h000;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        pixel_valid;
    logic [10:0] pixel_x;
    logic [9:0]  pixel_y;
    logic [10:0] sx [5];
    logic [9:0]  sy [5];
    logic        pacman_is_dead;
    logic [3:0]  pacman_dir;
    logic [11:0] rgb;
    logic        rgb_valid;
    logic [4:0]  sprite_hit;

    sprite_compositor dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .pixel_valid   (pixel_valid),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .pacman_pos_x  (sx[0]),
        .pacman_pos_y  (sy[0]),
        .blinky_pos_x  (sx[1]),
        .blinky_pos_y  (sy[1]),
        .pinky_pos_x   (sx[2]),
        .pinky_pos_y   (sy[2]),
        .inky_pos_x    (sx[3]),
        .inky_pos_y    (sy[3]),
        .clyde_pos_x   (sx[4]),
        .clyde_pos_y   (sy[4]),
        .pacman_is_dead(pacman_is_dead),
        .pacman_dir    (pacman_dir),
        .rgb           (rgb),
        .rgb_valid     (rgb_valid),
        .sprite_hit    (sprite_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] rgb;
        logic [4:0]  hit;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    int         m_sx [5];
    int         m_sy [5];
    bit         m_ok;
    bit         m_dying;
    int         m_cnt;
    logic [3:0] m_last_dir;
    int         m_frames;
    bit         m_prev_dead;

    logic       cur_dead;
    logic [3:0] cur_dir;

    function automatic logic [11:0] colour(input int i);
        case (i)
            0: return 12'hFF0;
            1: return 12'hF00;
            2: return 12'hF8F;
            3: return 12'h0FF;
            default: return 12'hF80;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_sx[i] = 0;
            m_sy[i] = 0;
        end
        m_ok        = 0;
        m_dying     = 0;
        m_cnt       = 0;
        m_last_dir  = 4'b0001;
        m_frames    = 0;
        m_prev_dead = 0;
    endtask

    // Geometric mouth: pixel lies ahead of Pac-Man's centre in the facing
    // direction, inside the 90-degree cone. Coordinates in half-pixels.
    function automatic bit in_mouth(input int lx, input int ly);
        int ux, uy, axial, perp;
        ux = 2 * lx - 15;
        uy = 2 * ly - 15;
        case (m_last_dir)
            4'b0010: begin axial = -uy; perp = ux; end
            4'b0100: begin axial = uy;  perp = ux; end
            4'b1000: begin axial = -ux; perp = uy; end
            default: begin axial = ux;  perp = uy; end
        endcase
        if (perp < 0) perp = -perp;
        return (axial > 0) && (perp < axial);
    endfunction

    task automatic predict(input int px, input int py, output logic [11:0] e_rgb, output logic [4:0] e_hit);
        logic [4:0] vis;
        e_hit = '0;
        e_rgb = BG;
        if (m_ok) begin
            for (int i = 0; i < 5; i++)
                if (px >= m_sx[i] && px < m_sx[i] + 16 && py >= m_sy[i] && py < m_sy[i] + 16)
                    e_hit[i] = 1'b1;
        end
`ifdef PACMAN_MOUTH_EN
        if (e_hit[0] && ((m_frames / 8) % 2 == 0) && in_mouth(px - m_sx[0], py - m_sy[0]))
            e_hit[0] = 1'b0;
`endif
        vis = e_hit;
        if (m_dying) begin
            vis[4:1] = '0;
            if ((m_cnt / 8) % 2 == 1) vis[0] = 1'b0;
        end
        for (int i = 4; i >= 0; i--)
            if (vis[i]) e_rgb = colour(i);
    endtask

    // Apply one cycle of stimulus, record the expectation, advance the model.
    task automatic drive(input bit fs, input bit pv, input int px, input int py);
        int   pxm, pym;
        exp_t e;
        pxm = px & 2047;
        pym = py & 1023;
        frame_start    = fs;
        pixel_valid    = pv;
        pixel_x        = 11'(pxm);
        pixel_y        = 10'(pym);
        pacman_is_dead = cur_dead;
        pacman_dir     = cur_dir;
        if (pv) begin
            predict(pxm, pym, e.rgb, e.hit);
            e.cyc = cyc;
            q.push_back(e);
        end
        if (fs) begin
            for (int i = 0; i < 5; i++) begin
                m_sx[i] = int'(sx[i]);
                m_sy[i] = int'(sy[i]);
            end
            m_ok = 1;
            if (cur_dir != 4'b0000) m_last_dir = cur_dir;
        end
        if (cur_dead && !m_prev_dead) begin
            m_dying = 1;
            m_cnt   = 0;
        end else if (fs && m_dying) begin
            if (m_cnt == 59) m_dying = 0;
            else m_cnt++;
        end
        m_prev_dead = cur_dead;
        if (fs) m_frames++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic rand_pixel(output int x, output int y);
        int i;
        if ($urandom_range(0, 4) == 0) begin
            x = $urandom_range(0, 2047);
            y = $urandom_range(0, 1023);
        end else begin
            i = $urandom_range(0, 4);
            x = m_sx[i] + $urandom_range(0, 23) - 4;
            y = m_sy[i] + $urandom_range(0, 23) - 4;
        end
    endtask

    task automatic rand_positions();
        int bx, by;
        if ($urandom_range(0, 5) == 0) begin
            bx = $urandom_range(2020, 2047);
            by = $urandom_range(1000, 1023);
        end else begin
            bx = $urandom_range(0, 640);
            by = $urandom_range(0, 480);
        end
        for (int i = 0; i < 5; i++) begin
            sx[i] = 11'(bx + $urandom_range(0, 20));
            sy[i] = 10'(by + $urandom_range(0, 20));
        end
    endtask

    function automatic logic [3:0] rand_dir();
        case ($urandom_range(0, 4))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic park_sprites();
        for (int i = 0; i < 5; i++) begin
            sx[i] = 11'(1200 + 100 * i);
            sy[i] = 10'(800);
        end
    endtask

    // Monitor: compare each presented pixel against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                while (q.size() > 0 && q[0].cyc + 2 < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_output: pixel issued at cycle %0d not presented by cycle %0d, expected rgb %03h",
                             q[0].cyc, cyc, q[0].rgb);
                    void'(q.pop_front());
                end
                if (rgb_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_valid: rgb_valid=1 rgb=%03h with no pixel pending, expected rgb_valid=0 (cycle %0d)",
                                 rgb, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("latency", 32'(cyc - e.cyc), 32'd2);
                        chk("rgb", 32'(rgb), 32'(e.rgb));
                        chk("sprite_hit", 32'(sprite_hit), 32'(e.hit));
                    end
                end else begin
                    chk("rgb_valid_idle", 32'(rgb_valid), 32'd0);
                    chk("rgb_idle", 32'(rgb), 32'(BG));
                end
            end
        end
    end

    initial begin : stimulus
        int x, y;
        rst            = 1'b0;
        frame_start    = 1'b0;
        pixel_valid    = 1'b0;
        pixel_x        = '0;
        pixel_y        = '0;
        cur_dead       = 1'b0;
        cur_dir        = 4'b0000;
        pacman_is_dead = 1'b0;
        pacman_dir     = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            sx[i] = '0;
            sy[i] = '0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", 32'(rgb), 32'(BG));
        chk("reset_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("reset_sprite_hit", 32'(sprite_hit), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Nothing is drawn before the first capture, even at shadow (0,0).
        drive(0, 1, 5, 5);
        drive(0, 1, 0, 0);
        drive(0, 0, 5, 5);

        // Pac-Man at the right edge of the visible area.
        park_sprites();
        sx[0] = 11'd624; sy[0] = 10'd32;
        cur_dir = 4'b0001;
        drive(1, 0, 0, 0);
        drive(0, 1, 624, 32);
        drive(0, 1, 640, 32);
        drive(0, 1, 623, 32);
        drive(0, 1, 639, 47);
        drive(0, 1, 639, 48);

        // Overlapping ghosts: blinky beats pinky.
        sx[1] = 11'd320; sy[1] = 10'd400;
        sx[2] = 11'd320; sy[2] = 10'd400;
        drive(1, 0, 0, 0);
        drive(0, 1, 325, 405);

        // Mid-frame position change is ignored until the next frame_start;
        // a pixel coinciding with frame_start still sees the old positions.
        sx[0] = 11'd100; sy[0] = 10'd100;
        drive(0, 1, 624, 32);
        drive(0, 1, 100, 100);
        drive(1, 1, 100, 100);
        drive(0, 1, 100, 100);
        drive(0, 1, 624, 32);

        // Randomized frames with deaths, restarts and edge clipping.
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 9) == 0) cur_dead = ~cur_dead;
            if ($urandom_range(0, 3) != 0) rand_positions();
            cur_dir = rand_dir();
            rand_pixel(x, y);
            drive(1, 1'($urandom_range(0, 1)), x, y);
            for (int p = 0; p < 16; p++) begin
                rand_pixel(x, y);
                drive(0, 1'($urandom_range(0, 3) != 0), x, y);
            end
        end

        // Full death sequence: blink pattern, hidden ghost, return to ALIVE.
        cur_dead = 1'b0;
        drive(0, 0, 0, 0);
        park_sprites();
        sx[0] = 11'd200; sy[0] = 10'd200;
        sx[1] = 11'd300; sy[1] = 10'd200;
        cur_dir = 4'b0000;
        drive(1, 0, 0, 0);
        cur_dead = 1'b1;
        drive(0, 1, 203, 207);
        for (int f = 0; f < 60; f++) begin
            drive(1, 0, 0, 0);
            drive(0, 1, 203, 207);
            drive(0, 1, 305, 205);
            drive(0, 1, 400, 400);
        end
        drive(0, 1, 305, 205);
        drive(0, 1, 203, 207);

        // Reset with pixels in flight.
        drive(0, 1, 305, 205);
        drive(0, 1, 203, 207);
        rst         = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        cur_dead    = 1'b0;
        pacman_is_dead = 1'b0;
        #1;
        chk("async_reset_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("async_reset_rgb", 32'(rgb), 32'(BG));
        chk("async_reset_sprite_hit", 32'(sprite_hit), 32'd0);
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1, 305, 205);
        drive(0, 1, 203, 207);

        // Mouth geometry, facing right at (0,0) on an open-mouth frame.
        park_sprites();
        sx[0] = 11'd0; sy[0] = 10'd0;
        cur_dir = 4'b0001;
        drive(1, 0, 0, 0);
        drive(0, 1, 15, 8);
        drive(0, 1, 2, 8);
        drive(0, 1, 8, 8);
        drive(0, 1, 8, 0);
        cur_dir = 4'b0010;
        drive(1, 0, 0, 0);
        drive(0, 1, 8, 0);
        drive(0, 1, 15, 8);

        repeat (5) drive(0, 0, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
